// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and defaults for the asynchronous FIFO and its read-side
// consumer.
//   DATA_WIDTH     : width of one FIFO word
//   data_t         : one FIFO word
//   RD_LAT_DEF     : default FIFO read latency (pop to valid data_out)
//   BUF_DEPTH_DEF  : default depth of the reader's holding buffer
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam int RD_LAT_DEF    = 1;
    localparam int BUF_DEPTH_DEF = 2;

endpackage

// File: rtl/fifo_reader_buf.sv
// -----------------------------------------------------------------------------
// fifo_reader_buf
// Circular holding buffer for fifo_reader. Words are written at the tail as
// they return from the FIFO and presented at the head to the stream.
// Pointers wrap naturally, so BUF_DEPTH must be a power of two.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset; empties the buffer and
//                 clears the storage so the head reads as zero
//   wr_en    in   write wr_data at the tail
//   wr_data  in   word to store
//   rd_en    in   retire the head word
//   rd_data  out  head word
//   occ      out  number of buffered words (0..BUF_DEPTH)
// -----------------------------------------------------------------------------
module fifo_reader_buf
    import fifo_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    localparam int PTR_W    = $clog2(BUF_DEPTH),
    localparam int OCC_W    = $clog2(BUF_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  data_t            wr_data,
    input  logic             rd_en,
    output data_t            rd_data,
    output logic [OCC_W-1:0] occ
);

    data_t             mem [BUF_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [OCC_W-1:0]  count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[tail] <= wr_data;
                tail      <= tail + PTR_W'(1);
            end
            if (rd_en) begin
                head <= head + PTR_W'(1);
            end
            // A simultaneous write and read leaves the occupancy unchanged.
            case ({wr_en, rd_en})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[head];
    assign occ     = count;

`ifndef SYNTHESIS
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= OCC_W'(BUF_DEPTH))
        else $error("fifo_reader_buf: occupancy above BUF_DEPTH");

    a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en |-> (count < OCC_W'(BUF_DEPTH)) || rd_en)
        else $error("fifo_reader_buf: tail write while full");

    a_no_read_empty: assert property (@(posedge clk) disable iff (!rst_n)
        rd_en |-> (count != '0))
        else $error("fifo_reader_buf: head read while empty");
`endif

endmodule

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
// Read-side consumer of the asynchronous FIFO, in the read clock domain.
// Turns the FIFO's pop/empty/data_out interface, which has a fixed read
// latency of RD_LAT cycles, into a valid/ready stream. Pops are issued only
// while a buffer entry is guaranteed for the returning word (credit rule), so
// the stream runs at one word per cycle under continuous m_ready and never
// overruns when downstream stalls.
//
// Parameters
//   RD_LAT     FIFO read latency, 1..2
//   BUF_DEPTH  holding-buffer entries, power of two, >= RD_LAT+1
//
// Ports
//   rd_clk      in   read-domain clock, rising edge
//   rd_rst      in   asynchronous active-low reset (shared with the FIFO)
//   fifo_data   in   FIFO data_out
//   fifo_empty  in   FIFO empty flag
//   fifo_pop    out  pop request to the FIFO
//   m_data      out  stream data (buffer head)
//   m_valid     out  stream valid
//   m_ready     in   stream ready
//   rd_count    out  saturating count of delivered words
//                    (only when FIFO_READER_CNT_EN is defined)
//
// Configuration macro: FIFO_READER_CNT_EN adds the rd_count port and counter.
// -----------------------------------------------------------------------------
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    input  data_t       fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_pop,
    output data_t       m_data,
    output logic        m_valid,
    input  logic        m_ready
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [31:0] rd_count
`endif
);

    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
    // Wide enough for occ + inflight without wrapping.
    localparam int CRD_W = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;

    logic [RD_LAT-1:0] pop_p;
    logic [CRD_W-1:0]  inflight;
    logic [CRD_W-1:0]  used;
    logic [OCC_W-1:0]  occ;
    logic              arrive;
    logic              take;

    assign take = m_valid && m_ready;

    // ---- stage p0..p(RD_LAT-1): pops waiting for their data ----
    // Bit 0 is the pop issued last cycle; the top bit marks the word that is
    // on fifo_data this cycle.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            pop_p <= '0;
        end else begin
            pop_p <= (pop_p << 1) | RD_LAT'(fifo_pop);
        end
    end

    assign arrive = pop_p[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CRD_W'(pop_p[i]);
        end
    end

    // Credits already committed, after the word leaving this cycle frees its
    // slot. take implies occ >= 1, so this never underflows.
    assign used = CRD_W'(occ) + inflight - CRD_W'(take);

    // Reset gates the pop as well, since it is otherwise purely combinational.
    assign fifo_pop = rd_rst && !fifo_empty && (used < CRD_W'(BUF_DEPTH));

    // ---- buffer stage: returned words wait here for the stream ----
    fifo_reader_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (rd_clk),
        .rst_n   (rd_rst),
        .wr_en   (arrive),
        .wr_data (fifo_data),
        .rd_en   (take),
        .rd_data (m_data),
        .occ     (occ)
    );

    assign m_valid = (occ != '0);

`ifdef FIFO_READER_CNT_EN
    logic [31:0] count;

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            count <= '0;
        end else if (take && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

    assign rd_count = count;
`endif

`ifndef SYNTHESIS
    a_stall_hold: assert property (@(posedge rd_clk) disable iff (!rd_rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)))
        else $error("fifo_reader: stream changed during stall");
`endif

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int L0 = 1;
    localparam int D0 = 2;
    localparam int L1 = 2;
    localparam int D1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  rd_rst;
    data_t fifo_data0, fifo_data1;
    logic  fifo_empty0, fifo_empty1;
    logic  fifo_pop0, fifo_pop1;
    data_t m_data0, m_data1;
    logic  m_valid0, m_valid1;
    logic  m_ready0, m_ready1;
`ifdef FIFO_READER_CNT_EN
    logic [31:0] rd_count0, rd_count1;
`endif

    fifo_reader #(.RD_LAT(L0), .BUF_DEPTH(D0)) dut (
        .rd_clk     (clk),
        .rd_rst     (rd_rst),
        .fifo_data  (fifo_data0),
        .fifo_empty (fifo_empty0),
        .fifo_pop   (fifo_pop0),
        .m_data     (m_data0),
        .m_valid    (m_valid0),
        .m_ready    (m_ready0)
`ifdef FIFO_READER_CNT_EN
        ,
        .rd_count   (rd_count0)
`endif
    );

    fifo_reader #(.RD_LAT(L1), .BUF_DEPTH(D1)) dut2 (
        .rd_clk     (clk),
        .rd_rst     (rd_rst),
        .fifo_data  (fifo_data1),
        .fifo_empty (fifo_empty1),
        .fifo_pop   (fifo_pop1),
        .m_data     (m_data1),
        .m_valid    (m_valid1),
        .m_ready    (m_ready1)
`ifdef FIFO_READER_CNT_EN
        ,
        .rd_count   (rd_count1)
`endif
    );

    // Reference model: the FIFO contents are an ordered list per instance.
    // src_rd counts words popped, out_rd counts words delivered; their
    // difference is everything the reader owes (buffered or in flight).
    data_t src_mem [2][256];
    int    pop_cyc [2][256];
    int    src_wr [2];
    int    src_rd [2];
    int    out_rd [2];
    int    arr [2];
    data_t dly [2][2];
    logic  pend_pop [2];
    data_t pend_word [2];
    logic  prev_stall [2];
    data_t prev_data [2];
    logic  s_pop [2];
    logic  s_valid [2];
    data_t s_data [2];
    int    cyc;
    int    n_chk;
    int    n_fail;

    function automatic int lat_of(input int k);
        return (k == 0) ? L0 : L1;
    endfunction

    function automatic int dep_of(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    task automatic push(input int k, input data_t w);
        src_mem[k][src_wr[k]] = w;
        src_wr[k]++;
        if (k == 0) fifo_empty0 = 1'b0;
        else        fifo_empty1 = 1'b0;
    endtask

    // One clock cycle: sample at the falling edge, check against the model,
    // then play the FIFO's side of the edge just after the rising edge.
    task automatic cycle();
        logic rdy [2];
        logic take;
        logic exp_valid;
        logic exp_pop;
        int   used;
        @(negedge clk);
        s_pop[0]   = fifo_pop0;  s_pop[1]   = fifo_pop1;
        s_valid[0] = m_valid0;   s_valid[1] = m_valid1;
        s_data[0]  = m_data0;    s_data[1]  = m_data1;
        rdy[0]     = m_ready0;   rdy[1]     = m_ready1;
        for (int k = 0; k < 2; k++) begin
            while (arr[k] < src_rd[k] && pop_cyc[k][arr[k]] + lat_of(k) + 1 <= cyc)
                arr[k]++;
            exp_valid = rd_rst && (arr[k] > out_rd[k]);
            n_chk++;
            if (s_valid[k] !== exp_valid) begin
                n_fail++;
                $display("FAIL model_valid inst=%0d cyc=%0d got=%b exp=%b", k, cyc, s_valid[k], exp_valid);
            end
            take = s_valid[k] && rdy[k];
            if (take) begin
                n_chk++;
                if (out_rd[k] >= src_rd[k] || s_data[k] !== src_mem[k][out_rd[k]]) begin
                    n_fail++;
                    $display("FAIL model_order inst=%0d cyc=%0d got=%h exp=%h", k, cyc, s_data[k],
                             (out_rd[k] < src_rd[k]) ? src_mem[k][out_rd[k]] : data_t'(0));
                end
                if (out_rd[k] < src_rd[k]) out_rd[k]++;
            end
            if (prev_stall[k]) begin
                n_chk++;
                if (s_valid[k] !== 1'b1 || s_data[k] !== prev_data[k]) begin
                    n_fail++;
                    $display("FAIL stall_hold inst=%0d cyc=%0d got=%b/%h exp=1/%h", k, cyc, s_valid[k], s_data[k], prev_data[k]);
                end
            end
            prev_stall[k] = s_valid[k] && !rdy[k];
            prev_data[k]  = s_data[k];
            used    = src_rd[k] - out_rd[k];
            exp_pop = rd_rst && (src_rd[k] != src_wr[k]) && (used < dep_of(k));
            n_chk++;
            if (s_pop[k] !== exp_pop) begin
                n_fail++;
                $display("FAIL credit_pop inst=%0d cyc=%0d got=%b exp=%b", k, cyc, s_pop[k], exp_pop);
            end
            pend_pop[k] = (s_pop[k] === 1'b1) && (src_rd[k] != src_wr[k]);
            if (pend_pop[k]) begin
                pop_cyc[k][src_rd[k]] = cyc;
                pend_word[k] = src_mem[k][src_rd[k]];
                src_rd[k]++;
            end
            n_chk++;
            if (src_rd[k] - out_rd[k] > dep_of(k)) begin
                n_fail++;
                $display("FAIL occupancy inst=%0d cyc=%0d got=%0d exp<=%0d", k, cyc, src_rd[k] - out_rd[k], dep_of(k));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            dly[k][1] = dly[k][0];
            dly[k][0] = pend_pop[k] ? pend_word[k] : data_t'($urandom);
        end
        fifo_data0  = dly[0][L0-1];
        fifo_data1  = dly[1][L1-1];
        fifo_empty0 = (src_rd[0] == src_wr[0]);
        fifo_empty1 = (src_rd[1] == src_wr[1]);
    endtask

    task automatic apply_reset();
        rd_rst = 1'b0;
        #1;
        n_chk++;
        if (fifo_pop0 !== 1'b0 || fifo_pop1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pop got=%b%b exp=00", fifo_pop0, fifo_pop1);
        end
        n_chk++;
        if (m_valid0 !== 1'b0 || m_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b%b exp=00", m_valid0, m_valid1);
        end
        n_chk++;
        if (m_data0 !== '0 || m_data1 !== '0) begin
            n_fail++;
            $display("FAIL reset_data got=%h/%h exp=00/00", m_data0, m_data1);
        end
        for (int k = 0; k < 2; k++) begin
            src_wr[k] = 0; src_rd[k] = 0; out_rd[k] = 0; arr[k] = 0;
            prev_stall[k] = 1'b0; pend_pop[k] = 1'b0;
            dly[k][0] = '0; dly[k][1] = '0;
        end
        fifo_empty0 = 1'b1; fifo_empty1 = 1'b1;
        fifo_data0  = '0;   fifo_data1  = '0;
        cycle();
        rd_rst = 1'b1;
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        m_ready0 = 1'b1; m_ready1 = 1'b1;
        fifo_empty0 = 1'b1; fifo_empty1 = 1'b1;
        fifo_data0 = '0; fifo_data1 = '0;
        cyc = 0;
        #2;
        apply_reset();
    endtask

    task automatic test_single_word();
        apply_reset();
        m_ready0 = 1'b1;
        push(0, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_chk++;
            if (s_pop[0] !== (i == 0)) begin
                n_fail++;
                $display("FAIL single_pop i=%0d got=%b exp=%b", i, s_pop[0], (i == 0));
            end
            n_chk++;
            if (s_valid[0] !== (i == 2)) begin
                n_fail++;
                $display("FAIL single_valid i=%0d got=%b exp=%b", i, s_valid[0], (i == 2));
            end
            if (i == 2) begin
                n_chk++;
                if (s_data[0] !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL single_data got=%h exp=a5", s_data[0]);
                end
            end
        end
    endtask

    task automatic test_burst();
        apply_reset();
        m_ready0 = 1'b1;
        for (int w = 0; w < 16; w++) push(0, data_t'(w));
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_chk++;
            if (s_pop[0] !== (i < 16)) begin
                n_fail++;
                $display("FAIL burst_pop i=%0d got=%b exp=%b", i, s_pop[0], (i < 16));
            end
            n_chk++;
            if (s_valid[0] !== (i >= 2 && i < 18)) begin
                n_fail++;
                $display("FAIL burst_valid i=%0d got=%b exp=%b", i, s_valid[0], (i >= 2 && i < 18));
            end
            if (i >= 2 && i < 18) begin
                n_chk++;
                if (s_data[0] !== data_t'(i - 2)) begin
                    n_fail++;
                    $display("FAIL burst_data i=%0d got=%h exp=%h", i, s_data[0], data_t'(i - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int w = 0; w < 8; w++) push(0, data_t'(8'h40 + w));
        for (int i = 0; i < 20; i++) begin
            m_ready0 = !(i >= 3 && i <= 9);
            cycle();
            if (i >= 3 && i <= 9) begin
                n_chk++;
                if (s_pop[0] !== 1'b0 || s_valid[0] !== 1'b1 || s_data[0] !== 8'h41) begin
                    n_fail++;
                    $display("FAIL bp_stall i=%0d got=pop%b vld%b %h exp=pop0 vld1 41", i, s_pop[0], s_valid[0], s_data[0]);
                end
            end
            if (i == 10) begin
                n_chk++;
                if (s_pop[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_resume got=%b exp=1", s_pop[0]);
                end
            end
            if (i == 17) begin
                n_chk++;
                if (s_valid[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_drained got=%b exp=0", s_valid[0]);
                end
            end
        end
        m_ready0 = 1'b1;
        n_chk++;
        if (out_rd[0] != 8) begin
            n_fail++;
            $display("FAIL bp_count got=%0d exp=8", out_rd[0]);
        end
    endtask

    task automatic test_lat2();
        int guard;
        apply_reset();
        m_ready1 = 1'b1;
        for (int w = 0; w < 8; w++) push(1, data_t'(8'h80 + w));
        for (int i = 0; i < 14; i++) begin
            cycle();
            n_chk++;
            if (s_pop[1] !== (i < 8)) begin
                n_fail++;
                $display("FAIL lat2_pop i=%0d got=%b exp=%b", i, s_pop[1], (i < 8));
            end
            n_chk++;
            if (s_valid[1] !== (i >= 3 && i < 11)) begin
                n_fail++;
                $display("FAIL lat2_valid i=%0d got=%b exp=%b", i, s_valid[1], (i >= 3 && i < 11));
            end
            if (i >= 3 && i < 11) begin
                n_chk++;
                if (s_data[1] !== data_t'(8'h80 + i - 3)) begin
                    n_fail++;
                    $display("FAIL lat2_data i=%0d got=%h exp=%h", i, s_data[1], data_t'(8'h80 + i - 3));
                end
            end
        end
        for (int w = 0; w < 20; w++) push(1, data_t'($urandom));
        guard = 0;
        while (out_rd[1] != src_wr[1] && guard < 400) begin
            m_ready1 = 1'($urandom_range(0, 1));
            cycle();
            guard++;
        end
        m_ready1 = 1'b1;
        n_chk++;
        if (out_rd[1] != src_wr[1]) begin
            n_fail++;
            $display("FAIL lat2_drain got=%0d exp=%0d", out_rd[1], src_wr[1]);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        m_ready1 = 1'b0;
        for (int w = 0; w < 3; w++) push(1, data_t'(8'h20 + w));
        for (int i = 0; i < 4; i++) cycle();
        n_chk++;
        if (s_valid[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got=%b exp=1", s_valid[1]);
        end
        apply_reset();
        m_ready1 = 1'b1;
        for (int w = 0; w < 4; w++) push(1, data_t'(8'h70 + w));
        for (int i = 0; i < 9; i++) begin
            cycle();
            n_chk++;
            if (s_valid[1] !== (i >= 3 && i < 7)) begin
                n_fail++;
                $display("FAIL midrst_valid i=%0d got=%b exp=%b", i, s_valid[1], (i >= 3 && i < 7));
            end
            if (i >= 3 && i < 7) begin
                n_chk++;
                if (s_data[1] !== data_t'(8'h70 + i - 3)) begin
                    n_fail++;
                    $display("FAIL midrst_data i=%0d got=%h exp=%h", i, s_data[1], data_t'(8'h70 + i - 3));
                end
            end
        end
    endtask

`ifdef FIFO_READER_CNT_EN
    task automatic test_counter();
        apply_reset();
        m_ready0 = 1'b1;
        for (int w = 0; w < 10; w++) push(0, data_t'(w));
        for (int i = 0; i < 14; i++) cycle();
        n_chk++;
        if (rd_count0 !== 32'd10) begin
            n_fail++;
            $display("FAIL cnt_ten got=%0d exp=10", rd_count0);
        end
        dut.count = 32'hFFFF_FFFE;
        for (int w = 0; w < 3; w++) push(0, data_t'(w));
        for (int i = 0; i < 8; i++) cycle();
        n_chk++;
        if (rd_count0 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL cnt_sat got=%h exp=ffffffff", rd_count0);
        end
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_single_word();
        test_burst();
        test_backpressure();
        test_lat2();
        test_mid_reset();
`ifdef FIFO_READER_CNT_EN
        test_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
